// File: rtl/div_cfg_scheduler.sv
// -----------------------------------------------------------------------------
// div_cfg_scheduler
//
// Purpose:
//   Shares one even-ratio clock divider between N_REQ requesters. Divisor
//   change requests are arbitrated round-robin. Only one request is in flight
//   at a time. A shadow copy of the divider's counter and phase lets a new
//   divisor be applied only at a full output-period boundary, which is the
//   divided clock's falling edge. As a result the divided clock never
//   produces a runt pulse.
//
// Ports:
//   i_clk        system clock (same clock as the divider)
//   i_rst_n      synchronous active-low reset
//   i_req        level request per requester, held until its o_ack
//   i_req_div    requested divisors, requester k uses [16k+15:16k]
//   o_ack        one-cycle pulse to the requester whose divisor was applied
//   o_divisor    registered divisor to the divider (0 = bypass)
//   o_update     one-cycle pulse when o_divisor takes a different value
//   o_busy       high from accept to apply and during the hold-off window
//   o_clamped    sticky "a request was clamped" flag (clamp build only)
//   o_dbg_state  current FSM state (0 idle, 1 wait, 2 apply)
//
// Handshake:
//   A requester raises i_req[k] with a stable i_req_div slice. It keeps
//   i_req[k] high until o_ack[k] pulses. The divisor is captured at accept.
//   Later changes to the slice, or dropping i_req[k], do not cancel the
//   captured request.
//
// Build option:
//   DIV_CFG_CLAMP_EN - when defined, captured divisors above MAX_DIV are
//   clamped to MAX_DIV and the o_clamped port exists.
// -----------------------------------------------------------------------------
module div_cfg_scheduler #(
   parameter int          N_REQ       = 4,
   parameter logic [15:0] RST_DIV     = 16'd0,
   parameter logic [15:0] HOLD_CYCLES = 16'd0,
   parameter logic [15:0] MAX_DIV     = 16'hFFFF
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic [N_REQ-1:0]     i_req,
   input  logic [16*N_REQ-1:0]  i_req_div,
   output logic [N_REQ-1:0]     o_ack,
   output logic [15:0]          o_divisor,
   output logic                 o_update,
   output logic                 o_busy,
`ifdef DIV_CFG_CLAMP_EN
   output logic                 o_clamped,
`endif
   output logic [1:0]           o_dbg_state
);

   localparam int PW = $clog2(N_REQ);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WAIT  = 2'd1,
      S_APPLY = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
   logic [PW-1:0]     pend_idx_q, pend_idx_d;
   logic [15:0]       pend_div_q, pend_div_d;
   logic [15:0]       divisor_q, divisor_d;
   logic [N_REQ-1:0]  ack_q, ack_d;
   logic              update_q, update_d;
   logic [15:0]       cnt_q, cnt_d;
   logic              phase_q, phase_d;
   logic [15:0]       hold_q, hold_d;
   logic              clamped_q, clamped_d;

   logic [15:0]       req_div_arr [N_REQ];
   logic              grant_found;
   logic [PW-1:0]     grant_idx;
   logic [PW-1:0]     cand_idx;
   int                cand;
   logic [15:0]       sel_div;
   logic [15:0]       latch_div;
   logic              latch_clamp;
   logic              boundary;
   logic              accept;

   // Split the flat divisor bus into one slice per requester.
   always_comb begin
      for (int k = 0; k < N_REQ; k++) begin
         req_div_arr[k] = i_req_div[16*k +: 16];
      end
   end

   // Round-robin pick: first set request at or after the pointer, wrapping.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      cand        = 0;
      cand_idx    = '0;
      for (int i = 0; i < N_REQ; i++) begin
         cand     = (int'(rr_ptr_q) + i) % N_REQ;
         cand_idx = PW'(cand);
         if (!grant_found && i_req[cand_idx]) begin
            grant_found = 1'b1;
            grant_idx   = cand_idx;
         end
      end
   end

   assign sel_div = req_div_arr[grant_idx];

`ifdef DIV_CFG_CLAMP_EN
   assign latch_clamp = (sel_div > MAX_DIV);
   assign latch_div   = latch_clamp ? MAX_DIV : sel_div;
`else
   logic unused_max_div;
   assign unused_max_div = ^MAX_DIV;
   assign latch_clamp    = 1'b0;
   assign latch_div      = sel_div;
`endif

   // Bypass (divisor 0) has no period, so every cycle counts as a boundary.
   // Otherwise the boundary is the last cycle of the high half-period, that
   // is, the divided clock is about to fall.
   assign boundary = (divisor_q == 16'd0) ||
                     ((cnt_q >= divisor_q - 16'd1) && phase_q);

   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      pend_idx_d = pend_idx_q;
      pend_div_d = pend_div_q;
      divisor_d  = divisor_q;
      ack_d      = '0;
      update_d   = 1'b0;
      clamped_d  = clamped_q;
      accept     = 1'b0;
      hold_d     = (hold_q != 16'd0) ? hold_q - 16'd1 : 16'd0;

      // Free-running shadow of the divider's counter and output phase.
      if (divisor_q == 16'd0) begin
         cnt_d   = 16'd0;
         phase_d = 1'b0;
      end else if (cnt_q >= divisor_q - 16'd1) begin
         cnt_d   = 16'd0;
         phase_d = ~phase_q;
      end else begin
         cnt_d   = cnt_q + 16'd1;
         phase_d = phase_q;
      end

      case (state_q)
         S_IDLE: begin
            if ((hold_q == 16'd0) && grant_found) begin
               accept     = 1'b1;
               pend_idx_d = grant_idx;
               pend_div_d = latch_div;
               clamped_d  = clamped_q | latch_clamp;
               rr_ptr_d   = (grant_idx == PW'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
               state_d    = S_WAIT;
            end
         end
         S_WAIT: begin
            // A request for the divisor already in use needs no boundary.
            if (boundary || (pend_div_q == divisor_q)) begin
               divisor_d            = pend_div_q;
               update_d             = (pend_div_q != divisor_q);
               ack_d[pend_idx_q]    = 1'b1;
               // The divider restarts its period on every divisor write.
               cnt_d                = 16'd0;
               phase_d              = 1'b0;
               hold_d               = HOLD_CYCLES;
               state_d              = S_APPLY;
            end
         end
         S_APPLY: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q    <= S_IDLE;
         rr_ptr_q   <= '0;
         pend_idx_q <= '0;
         pend_div_q <= 16'd0;
         divisor_q  <= RST_DIV;
         ack_q      <= '0;
         update_q   <= 1'b0;
         cnt_q      <= 16'd0;
         phase_q    <= 1'b0;
         hold_q     <= 16'd0;
         clamped_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         pend_idx_q <= pend_idx_d;
         pend_div_q <= pend_div_d;
         divisor_q  <= divisor_d;
         ack_q      <= ack_d;
         update_q   <= update_d;
         cnt_q      <= cnt_d;
         phase_q    <= phase_d;
         hold_q     <= hold_d;
         clamped_q  <= clamped_d;
      end
   end

   assign o_ack       = ack_q;
   assign o_divisor   = divisor_q;
   assign o_update    = update_q;
   // Busy also covers the accepting cycle, so it stays high across
   // back-to-back grants separated by the hold-off window.
   assign o_busy      = (state_q != S_IDLE) || (hold_q != 16'd0) || accept;
   assign o_dbg_state = state_q;

`ifdef DIV_CFG_CLAMP_EN
   assign o_clamped = clamped_q;
`else
   logic unused_clamped;
   assign unused_clamped = clamped_q;
`endif

endmodule
